// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: NOP encoding, PC step,
// fetch FSM states and the {pc, inst} entry handed to decode.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      RUN,
      WAIT,
      DROP
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} pairs; flush wins over any same-cycle push or pop.
module fetch_queue
   import fetch_stage_pkg::*;
#(
   parameter fetch_entry_t RESET_ENTRY = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t data_i,
   output logic [1:0]   count_o,
   output logic         valid_o,
   output fetch_entry_t head_o
);

   logic [1:0]   count_q, count_d;
   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) head_d = data_i;
               else                 tail_d = data_i;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = data_i;
               end else begin
                  head_d = tail_q;
                  tail_d = data_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Head is reset so the decode-facing PC shows the reset address before any fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= RESET_ENTRY;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      tail_q <= tail_d;
   end

   assign count_o = count_q;
   assign valid_o = (count_q != 2'd0);
   assign head_o  = head_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: one outstanding imem read, 2-entry queue, redirect flush.
// Optional misaligned-redirect detection is built when IF_ALIGN_CHECK_EN is defined.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_IF_pause,
   input  logic        i_IF_redirect,
   input  logic [31:0] i_IF_target,
   output logic        o_IF_imemReq,
   output logic [31:0] o_IF_imemAddr,
   input  logic        i_IF_imemGnt,
   input  logic        i_IF_imemRValid,
   input  logic [31:0] i_IF_imemRData,
   output logic        o_IF_valid,
   output logic [31:0] o_IF_PC,
   output logic [31:0] o_IF_inst,
   output logic        o_IF_addrErr
);

   fetch_state_e state_q;
   logic [31:0]  fpc_q;
   logic [31:0]  ipc_q;
   logic         err_q;
   logic [31:0]  target;
   logic [1:0]   q_count;
   logic [1:0]   occ;
   logic         q_valid;
   fetch_entry_t q_head;
   fetch_entry_t push_entry;
   logic         gnt_acc;
   logic         push;
   logic         pop;

`ifdef IF_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                err_q <= 1'b0;
      else if (i_IF_redirect) err_q <= (i_IF_target[1:0] != 2'b00);
   end
   assign target       = {i_IF_target[31:2], 2'b00};
   assign o_IF_addrErr = err_q;
`else
   assign err_q        = 1'b0;
   assign target       = {i_IF_target[31:2], i_IF_target[1:0] & 2'b00};
   assign o_IF_addrErr = 1'b0;
`endif

   // The in-flight read reserves a queue slot, so a response always has room.
   assign occ           = q_count + {1'b0, (state_q == WAIT)};
   assign o_IF_imemReq  = !rst && (state_q == RUN) && (occ < 2'd2) && !i_IF_redirect && !err_q;
   assign o_IF_imemAddr = fpc_q;
   assign gnt_acc       = o_IF_imemReq && i_IF_imemGnt;
   assign push          = (state_q == WAIT) && i_IF_imemRValid && !i_IF_redirect;
   assign pop           = q_valid && !i_IF_pause && !i_IF_redirect;
   assign push_entry    = '{pc: ipc_q, inst: i_IF_imemRData};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         fpc_q   <= RESET_PC;
         ipc_q   <= RESET_PC;
      end else begin
         case (state_q)
            RUN:     if (gnt_acc) state_q <= WAIT;
            WAIT: begin
               if (i_IF_imemRValid)    state_q <= RUN;
               else if (i_IF_redirect) state_q <= DROP;
            end
            DROP:    if (i_IF_imemRValid) state_q <= RUN;
            default: state_q <= RUN;
         endcase
         if (i_IF_redirect) begin
            fpc_q <= target;
         end else if (gnt_acc) begin
            fpc_q <= fpc_q + PC_STEP;
            ipc_q <= fpc_q;
         end
      end
   end

   fetch_queue #(
      .RESET_ENTRY('{pc: RESET_PC, inst: NOP_INST})
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (i_IF_redirect),
      .data_i  (push_entry),
      .count_o (q_count),
      .valid_o (q_valid),
      .head_o  (q_head)
   );

   assign o_IF_valid = q_valid;
   assign o_IF_PC    = q_head.pc;
   assign o_IF_inst  = q_valid ? q_head.inst : NOP_INST;

endmodule
